// File: rtl/mips_defs.sv
// Shared MIPS decode definitions: opcode/funct codes, write-back select and
// load-extend encodings, and the retiring-instruction decode helper.
package mips_defs;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0a;
    localparam logic [5:0] OP_ANDI    = 6'h0c;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    localparam logic [4:0] REG_RA     = 5'd31;

    typedef enum logic [2:0] {
        WB_NONE,
        WB_ALU,
        WB_DM,
        WB_SHIFT,
        WB_PC8
    } wb_sel_e;

    typedef enum logic [2:0] {
        LX_WORD,
        LX_BYTE_S,
        LX_BYTE_U,
        LX_HALF_S,
        LX_HALF_U
    } lx_e;

    typedef struct packed {
        wb_sel_e    sel;
        lx_e        lx;
        logic [4:0] dest;
    } wb_ctrl_t;

    // A bubble (all zeros) decodes as sll $0, which the dest!=0 rule then suppresses.
    function automatic wb_ctrl_t decode_wb(input logic [31:0] instr,
                                           input logic [4:0]  rd,
                                           input logic [4:0]  rt);
        wb_ctrl_t c;
        c.sel  = WB_NONE;
        c.lx   = LX_WORD;
        c.dest = 5'd0;
        unique case (instr[31:26])
            OP_SPECIAL: begin
                c.dest = rd;
                unique case (instr[5:0])
                    FN_SLL, FN_SRL, FN_SRA: c.sel = WB_SHIFT;
                    FN_JALR:                c.sel = WB_PC8;
                    FN_JR: begin
                        c.sel  = WB_NONE;
                        c.dest = 5'd0;
                    end
                    default:                c.sel = WB_ALU;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
                c.sel  = WB_ALU;
                c.dest = rt;
            end
            OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
                c.sel  = WB_DM;
                c.dest = rt;
                unique case (instr[31:26])
                    OP_LB:   c.lx = LX_BYTE_S;
                    OP_LBU:  c.lx = LX_BYTE_U;
                    OP_LH:   c.lx = LX_HALF_S;
                    OP_LHU:  c.lx = LX_HALF_U;
                    default: c.lx = LX_WORD;
                endcase
            end
            OP_JAL: begin
                c.sel  = WB_PC8;
                c.dest = REG_RA;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/grf_array.sv
// 31x32 general register file ($0 hard-wired to zero) with one write port and
// two read ports that bypass the in-flight write.
module grf_array (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_b
);

    logic [31:0] regs [1:31];

    // NOTE: this array is built from flops, not a RAM macro, so it can take the
    // asynchronous clear; a RAM-inferred file must not be reset this way.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != 5'd0) begin
            // NOTE: state updates use non-blocking assignment so every flop
            // samples pre-edge values regardless of statement order.
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch.
        rdata_a = '0;
        if (raddr_a != 5'd0) begin
            if (we && raddr_a == waddr) rdata_a = wdata;
            else                        rdata_a = regs[raddr_a];
        end
    end

    always_comb begin
        rdata_b = '0;
        if (raddr_b != 5'd0) begin
            if (we && raddr_b == waddr) rdata_b = wdata;
            else                        rdata_b = regs[raddr_b];
        end
    end

endmodule

// File: rtl/wb_stage.sv
// MIPS writeback stage: decodes the MEM/WB instruction, extracts load data,
// drives the forwarding bus, owns the register file and counts retirements.
module wb_stage
    import mips_defs::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         in_PC,
    input  logic [31:0]         in_instruction,
    input  logic [31:0]         in_ALUout,
    input  logic [31:0]         in_DMout,
    input  logic [31:0]         in_addr_rd,
    input  logic [31:0]         in_addr_rt,
    input  logic [31:0]         in_Shift,
    input  logic [4:0]          rs_addr,
    input  logic [4:0]          rt_addr,
    output logic [31:0]         rs_data,
    output logic [31:0]         rt_data,
    output logic                wb_we,
    output logic [4:0]          wb_addr,
    output logic [31:0]         wb_data,
    output logic [RETIRE_W-1:0] retire_count
);

    wb_ctrl_t    ctrl;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;
    logic [31:0] sel_data;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^{in_addr_rd[31:5], in_addr_rt[31:5]};

    assign ctrl = decode_wb(in_instruction, in_addr_rd[4:0], in_addr_rt[4:0]);

    always_comb begin
        ld_byte = in_DMout[7:0];
        unique case (in_ALUout[1:0])
            2'd0: ld_byte = in_DMout[7:0];
            2'd1: ld_byte = in_DMout[15:8];
            2'd2: ld_byte = in_DMout[23:16];
            2'd3: ld_byte = in_DMout[31:24];
            default: ;
        endcase
    end

    assign ld_half = in_ALUout[1] ? in_DMout[31:16] : in_DMout[15:0];

    always_comb begin
        ld_value = in_DMout;
        unique case (ctrl.lx)
            LX_BYTE_S: ld_value = {{24{ld_byte[7]}}, ld_byte};
            LX_BYTE_U: ld_value = {24'd0, ld_byte};
            LX_HALF_S: ld_value = {{16{ld_half[15]}}, ld_half};
            LX_HALF_U: ld_value = {16'd0, ld_half};
            default:   ld_value = in_DMout;
        endcase
    end

    always_comb begin
        sel_data = '0;
        unique case (ctrl.sel)
            WB_ALU:   sel_data = in_ALUout;
            WB_DM:    sel_data = ld_value;
            WB_SHIFT: sel_data = in_Shift;
            WB_PC8:   sel_data = in_PC + 32'd8;
            default:  sel_data = '0;
        endcase
    end

    // Gating with reset keeps the bypass quiet too, so reads return 0 during reset.
    assign wb_we   = reset && (ctrl.sel != WB_NONE) && (ctrl.dest != 5'd0);
    assign wb_addr = wb_we ? ctrl.dest : 5'd0;
    assign wb_data = wb_we ? sel_data  : 32'd0;

    grf_array u_grf (
        .clk     (clk),
        .reset   (reset),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs_addr),
        .rdata_a (rs_data),
        .raddr_b (rt_addr),
        .rdata_b (rt_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_count <= '0;
        end else if (in_instruction != 32'd0) begin
            retire_count <= retire_count + RETIRE_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage with a 4-bit retire counter so the
// wrap-around is reachable in a handful of cycles.
module tb_wb_stage;

    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   in_PC, in_instruction, in_ALUout, in_DMout;
    logic [31:0]   in_addr_rd, in_addr_rt, in_Shift;
    logic [4:0]    rs_addr, rt_addr;
    logic [31:0]   rs_data, rt_data;
    logic          wb_we;
    logic [4:0]    wb_addr;
    logic [31:0]   wb_data;
    logic [RW-1:0] retire_count;

    int            errors = 0;
    int            checks = 0;
    logic [RW-1:0] exp_cnt = '0;

    always #5 clk = ~clk;

    wb_stage #(.RETIRE_W(RW)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_PC          (in_PC),
        .in_instruction (in_instruction),
        .in_ALUout      (in_ALUout),
        .in_DMout       (in_DMout),
        .in_addr_rd     (in_addr_rd),
        .in_addr_rt     (in_addr_rt),
        .in_Shift       (in_Shift),
        .rs_addr        (rs_addr),
        .rs_data        (rs_data),
        .rt_addr        (rt_addr),
        .rt_data        (rt_data),
        .wb_we          (wb_we),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .retire_count   (retire_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; the bench's own counter model tracks retirements.
    task automatic tick();
        if (reset && in_instruction != 32'd0) exp_cnt = exp_cnt + 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] rd, input logic [31:0] rt,
                         input logic [31:0] alu, input logic [31:0] dm, input logic [31:0] sh,
                         input logic [31:0] pc);
        in_instruction = instr;
        in_addr_rd     = rd;
        in_addr_rt     = rt;
        in_ALUout      = alu;
        in_DMout       = dm;
        in_Shift       = sh;
        in_PC          = pc;
        #1;
    endtask

    task automatic check_wb(input string tag, input logic we, input logic [4:0] addr,
                            input logic [31:0] data);
        check({tag, ".we"},   {31'd0, wb_we}, {31'd0, we});
        check({tag, ".addr"}, {27'd0, wb_addr}, {27'd0, addr});
        check({tag, ".data"}, wb_data, data);
    endtask

    initial begin
        // Reset held low with a write-class instruction on the inputs.
        reset   = 1'b0;
        rs_addr = 5'd5;
        rt_addr = 5'd5;
        drive(32'h3405_1234, 32'd0, 32'd5, 32'h0000_1234, 32'hFFFF_FFFF, 32'h1, 32'h100);
        check_wb("reset_wb", 1'b0, 5'd0, 32'd0);
        check("reset_rs", rs_data, 32'd0);
        check("reset_rt", rt_data, 32'd0);
        tick();
        tick();
        check("reset_cnt", {28'd0, retire_count}, 32'd0);

        // Release with bubbles: count must stay 0.
        drive(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        reset = 1'b1;
        tick();
        tick();
        check("bubble_cnt", {28'd0, retire_count}, 32'd0);
        check_wb("bubble_wb", 1'b0, 5'd0, 32'd0);

        // ori $5: bypass same cycle, array next cycle.
        drive(32'h3405_1234, 32'd0, 32'd5, 32'h0000_1234, 32'd0, 32'd0, 32'h0);
        check_wb("ori", 1'b1, 5'd5, 32'h0000_1234);
        check("ori_bypass_rs", rs_data, 32'h0000_1234);
        check("ori_bypass_rt", rt_data, 32'h0000_1234);
        tick();
        drive(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        check("ori_array_rs", rs_data, 32'h0000_1234);
        check("ori_cnt", {28'd0, retire_count}, 32'd1);

        // Loads: byte/half selection and extension.
        drive(32'h8006_0003, 32'd0, 32'd6, 32'h0000_0003, 32'h80FF_7F01, 32'd0, 32'd0);
        check_wb("lb_a3", 1'b1, 5'd6, 32'hFFFF_FF80);
        tick();
        drive(32'h9407_0000, 32'd0, 32'd7, 32'h0000_0000, 32'h80FF_7F01, 32'd0, 32'd0);
        check_wb("lhu_h0", 1'b1, 5'd7, 32'h0000_7F01);
        tick();
        drive(32'h8408_0002, 32'd0, 32'd8, 32'h0000_0002, 32'h80FF_7F01, 32'd0, 32'd0);
        check_wb("lh_h1", 1'b1, 5'd8, 32'hFFFF_80FF);
        tick();
        drive(32'h900A_0001, 32'd0, 32'd10, 32'h0000_0001, 32'h80FF_7F01, 32'd0, 32'd0);
        check_wb("lbu_a1", 1'b1, 5'd10, 32'h0000_007F);
        tick();
        drive(32'h8C0B_0000, 32'd0, 32'd11, 32'h0000_0000, 32'h80FF_7F01, 32'd0, 32'd0);
        check_wb("lw", 1'b1, 5'd11, 32'h80FF_7F01);
        tick();

        // Array contents after the loads, including both ports on one address.
        drive(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        rs_addr = 5'd6;  rt_addr = 5'd7;
        #1;
        check("grf_r6", rs_data, 32'hFFFF_FF80);
        check("grf_r7", rt_data, 32'h0000_7F01);
        rs_addr = 5'd11; rt_addr = 5'd11;
        #1;
        check("grf_r11_a", rs_data, 32'h80FF_7F01);
        check("grf_r11_b", rt_data, 32'h80FF_7F01);

        // Links: jal to $31, PC+8 wraps modulo 2^32; jalr with rd=0 is dropped.
        drive(32'h0C00_0C00, 32'd4, 32'd9, 32'd0, 32'd0, 32'd0, 32'h0000_3000);
        check_wb("jal", 1'b1, 5'd31, 32'h0000_3008);
        tick();
        drive(32'h0C00_0000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFC);
        check_wb("jal_wrap", 1'b1, 5'd31, 32'h0000_0004);
        tick();
        drive(32'h0020_0009, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h0000_4000);
        check_wb("jalr_rd0", 1'b0, 5'd0, 32'd0);
        tick();
        check("jalr_cnt", {28'd0, retire_count}, {28'd0, exp_cnt});

        // addu rd=0: no write and $0 still reads 0.
        rs_addr = 5'd0; rt_addr = 5'd0;
        drive(32'h0022_0021, 32'd0, 32'd2, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0);
        check_wb("addu_rd0", 1'b0, 5'd0, 32'd0);
        check("r0_rs", rs_data, 32'd0);
        check("r0_rt", rt_data, 32'd0);
        tick();

        // Shift writes rd from in_Shift; jr, sw, beq write nothing but retire.
        drive(32'h0001_3880, 32'd7, 32'd1, 32'h1111_1111, 32'd0, 32'h0000_0055, 32'd0);
        check_wb("sll", 1'b1, 5'd7, 32'h0000_0055);
        tick();
        drive(32'h03E0_0008, 32'd3, 32'd3, 32'h1, 32'd0, 32'd0, 32'h10);
        check_wb("jr", 1'b0, 5'd0, 32'd0);
        tick();
        drive(32'hAC05_0000, 32'd5, 32'd5, 32'h2, 32'h3, 32'd0, 32'h0);
        check_wb("sw", 1'b0, 5'd0, 32'd0);
        tick();
        check("sw_cnt", {28'd0, retire_count}, {28'd0, exp_cnt});
        drive(32'h1085_0004, 32'd5, 32'd5, 32'h2, 32'h3, 32'd0, 32'h0);
        check_wb("beq", 1'b0, 5'd0, 32'd0);
        tick();

        // Fill the counter to all ones, then wrap.
        for (int n = 0; n < 20 && exp_cnt != 4'hF; n++) begin
            drive(32'hAC00_0000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
            tick();
        end
        check("cnt_full", {28'd0, retire_count}, 32'h0000_000F);
        drive(32'hAC00_0000, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick();
        check("cnt_wrap", {28'd0, retire_count}, 32'd0);

        // Reset asserted between edges while a write to $9 is pending.
        rs_addr = 5'd9; rt_addr = 5'd5;
        drive(32'h3409_ABCD, 32'd0, 32'd9, 32'h0000_ABCD, 32'd0, 32'd0, 32'd0);
        check_wb("pending", 1'b1, 5'd9, 32'h0000_ABCD);
        reset = 1'b0;
        #1;
        check_wb("mid_reset_wb", 1'b0, 5'd0, 32'd0);
        check("mid_reset_r9", rs_data, 32'd0);
        check("mid_reset_r5", rt_data, 32'd0);
        tick();
        drive(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        reset   = 1'b1;
        exp_cnt = '0;
        tick();
        check("after_reset_r9", rs_data, 32'd0);
        check("after_reset_r5", rt_data, 32'd0);
        check("after_reset_cnt", {28'd0, retire_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
